// File: rtl/aes_pkg.sv
// Shared AES decryption helpers: GF(2^8) constant multipliers, the row-major
// byte-position helper for 128-bit states, and FSM state encodings.
package aes_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // MSB index of byte (row r, column c); {r, c, 3'b000} equals 8*(4r+c).
    function automatic logic [6:0] byte_pos(input logic [1:0] r, input logic [1:0] c);
        return 7'd127 - {r, c, 3'b000};
    endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns on one 32-bit column, a0 in the MSB byte.
module inv_mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
    assign col_out[23:16] = gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
    assign col_out[15:8]  = gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3);
    assign col_out[7:0]   = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: COLS_PER_CYCLE shared column datapaths walk the
// work register under a valid/ready handshake; bypass serves the final round.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for in_valid
// BUSY    | transforming column groups selected by col_cnt
// DONE    | out_valid=1, holding out_state until out_ready
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         asy_reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0]   state;
    logic [1:0]   col_cnt;
    logic [127:0] work;
    logic [127:0] work_nxt;
    logic         last_group;
    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = col_cnt + 2'(g);

        always_comb begin
            col_in[g] = '0;
            for (int r = 0; r < 4; r++) begin
                col_in[g][31-8*r -: 8] = work[byte_pos(2'(r), col_idx[g]) -: 8];
            end
        end

        inv_mix_column_word u_word (
            .col_in  (col_in[g]),
            .col_out (col_out[g])
        );
    end

    // Splice transformed columns back in; untouched columns pass through.
    always_comb begin
        work_nxt = work;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            for (int r = 0; r < 4; r++) begin
                work_nxt[byte_pos(2'(r), col_idx[g]) -: 8] = col_out[g][31-8*r -: 8];
            end
        end
    end

    assign last_group = (col_cnt == 2'(4 - COLS_PER_CYCLE));
    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);

    always_ff @(posedge clk or negedge asy_reset) begin
        if (!asy_reset) begin
            state     <= ST_IDLE;
            col_cnt   <= 2'd0;
            work      <= '0;
            out_state <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work    <= in_state;
                        col_cnt <= 2'd0;
                        if (in_bypass) begin
                            out_state <= in_state;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    work    <= work_nxt;
                    col_cnt <= col_cnt + 2'(COLS_PER_CYCLE);
                    if (last_group) begin
                        out_state <= work_nxt;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
